random_weight_streamer: RTL and testbench

Parametrised pseudo-random weight source for the neural-network datapath. A `start` command sets the matrix dimensions (`no_of_rows` × `no_of_columns`), and the block streams that many DATA_W-bit signed weights in row-major order over a valid/ready interface. Each word carries its row and column indices. The weights come from a seedable 32-bit Galois LFSR, with three output modes: raw, scaled, and binary ±1. The consumer is the weight-memory loader, and the LFSR state persists across runs.

---
 rtl/random_weight_streamer.sv | 248 ++++++++++++++++++++++++
 tb/tb_random_weight_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_weight_streamer.sv
// ---------------------------------------------------------------------------
// random_weight_streamer
//
// Pseudo-random weight source for the neural-network datapath. A start
// command latches a rows x columns matrix size and an output mode, then the
// block streams that many signed weights in row-major order over a
// valid/ready interface, tagging every word with its row and column index.
// Weights come from a seedable 32-bit Galois LFSR whose state survives from
// one run to the next, so consecutive runs continue the same sequence.
//
// Parameters
//   DATA_W        weight width (at most 32), signed two's complement
//   DIM_W         width of the row/column counts and indices
//   SEED          LFSR value after reset, also used in place of a zero seed
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a run (sampled in IDLE only)
//   no_of_rows    row count, latched on an accepted start
//   no_of_columns column count, latched on an accepted start
//   mode          0 raw, 1 scaled, 2 binary +/-1, 3 behaves as raw
//   shift_amt     arithmetic right shift used by the scaled mode
//   seed_load     load seed_in into the LFSR (IDLE only)
//   seed_in       seed value
//   w_data        current weight
//   w_row/w_col   indices of w_data
//   w_last        final element of the run
//   w_valid       weight available
//   w_ready       consumer accepts the current weight
//   busy          high while a run is in progress or finishing
//   done          one-cycle pulse after the final handshake
//   err           one-cycle pulse after a start with a zero dimension
// ---------------------------------------------------------------------------
module random_weight_streamer #(
   parameter int          DATA_W = 16,
   parameter int          DIM_W  = 8,
   parameter logic [31:0] SEED   = 32'hACE1_0001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  no_of_rows,
   input  logic [DIM_W-1:0]  no_of_columns,
   input  logic [1:0]        mode,
   input  logic [3:0]        shift_amt,
   input  logic              seed_load,
   input  logic [31:0]       seed_in,
   output logic [DATA_W-1:0] w_data,
   output logic [DIM_W-1:0]  w_row,
   output logic [DIM_W-1:0]  w_col,
   output logic              w_last,
   output logic              w_valid,
   input  logic              w_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // FSM encoding; the spare code 2'd3 is unreachable and decays to IDLE
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [31:0]       LFSR_TAPS   = 32'h8020_0003;
   localparam logic [DIM_W-1:0]  IDX_ONE     = DIM_W'(1);
   localparam logic [DATA_W-1:0] W_PLUS_ONE  = DATA_W'(1);
   localparam logic [DATA_W-1:0] W_MINUS_ONE = '1;

   localparam logic [1:0] MODE_SCALED = 2'd1;
   localparam logic [1:0] MODE_BINARY = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [31:0]       lfsr;
   logic [31:0]       lfsr_advanced;
   logic [31:0]       seed_value;
   logic [DIM_W-1:0]  rows_q;
   logic [DIM_W-1:0]  cols_q;
   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  col_q;
   logic [1:0]        mode_q;
   logic [3:0]        shift_q;
   logic              err_q;

   logic              in_idle;
   logic              in_run;
   logic              in_done;
   logic              handshake;
   logic              col_at_end;
   logic              row_at_end;
   logic              dims_ok;
   logic              start_ok;
   logic              start_bad;
   logic [DATA_W-1:0] weight;

   // State decodes and the handshake. The datapath only moves on an accepted
   // word, which can only happen while RUN is presenting one.
   assign in_idle   = (state == ST_IDLE);
   assign in_run    = (state == ST_RUN);
   assign in_done   = (state == ST_DONE);
   assign handshake = in_run && w_ready;

   // Position tests against the latched dimensions; these drive both the
   // index wrap and w_last.
   assign col_at_end = (col_q == (cols_q - IDX_ONE));
   assign row_at_end = (row_q == (rows_q - IDX_ONE));

   // A start is accepted only in IDLE and only with two nonzero dimensions;
   // a start with a zero dimension is turned into an err pulse instead.
   assign dims_ok   = (no_of_rows != '0) && (no_of_columns != '0);
   assign start_ok  = in_idle && start && dims_ok;
   assign start_bad = in_idle && start && !dims_ok;

   // One Galois step: shift right and fold the taps back in when a one
   // falls out of bit 0.
   assign lfsr_advanced = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

   // An all-zero LFSR would lock up, so a zero seed is replaced by SEED.
   assign seed_value = (seed_in == '0) ? SEED : seed_in;

   // Next-state logic for the three-state run controller
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (handshake && col_at_end && row_at_end) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // LFSR: seeding is only honoured in IDLE, and a seed_load in the same
   // cycle as start lands first so the run begins from the new seed. During
   // a run the register advances once per accepted word, which keeps the
   // presented weight steady across stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else if (in_idle && seed_load) begin
         lfsr <= seed_value;
      end else if (handshake) begin
         lfsr <= lfsr_advanced;
      end
   end

   // Run configuration is captured on an accepted start so later changes on
   // the inputs cannot disturb a run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_q  <= '0;
         cols_q  <= '0;
         mode_q  <= '0;
         shift_q <= '0;
      end else if (start_ok) begin
         rows_q  <= no_of_rows;
         cols_q  <= no_of_columns;
         mode_q  <= mode;
         shift_q <= shift_amt;
      end
   end

   // Row-major index counters. The column wraps at the last column and
   // carries into the row; after the final element both wrap to zero so the
   // counters sit cleared between runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else if (start_ok) begin
         row_q <= '0;
         col_q <= '0;
      end else if (handshake) begin
         if (col_at_end) begin
            col_q <= '0;
            if (row_at_end) begin
               row_q <= '0;
            end else begin
               row_q <= row_q + IDX_ONE;
            end
         end else begin
            col_q <= col_q + IDX_ONE;
         end
      end
   end

   // err is registered so it appears the cycle after the rejected start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= start_bad;
      end
   end

   // Weight shaping from the current LFSR state. The scaled mode is an
   // arithmetic shift of the low DATA_W bits read as a signed value; the
   // binary mode maps bit 0 onto +1 / -1. The reserved mode code falls into
   // the raw case.
   always_comb begin
      weight = lfsr[DATA_W-1:0];
      case (mode_q)
         MODE_SCALED: begin
            weight = $signed(lfsr[DATA_W-1:0]) >>> shift_q;
         end
         MODE_BINARY: begin
            weight = lfsr[0] ? W_PLUS_ONE : W_MINUS_ONE;
         end
         default: begin
            weight = lfsr[DATA_W-1:0];
         end
      endcase
   end

   // Outputs are decoded from registered state only, so they hold steady
   // while the consumer stalls. The data and index fields are forced to
   // zero outside RUN, which also gives the all-zero picture on reset.
   assign w_valid = in_run;
   assign w_data  = in_run ? weight : '0;
   assign w_row   = in_run ? row_q : '0;
   assign w_col   = in_run ? col_q : '0;
   assign w_last  = in_run && col_at_end && row_at_end;
   assign busy    = in_run || in_done;
   assign done    = in_done;
   assign err     = err_q;

endmodule

// File: tb/tb_random_weight_streamer.sv
// ---------------------------------------------------------------------------
// tb_random_weight_streamer
//
// Self-checking bench for random_weight_streamer. A reference LFSR and
// weight function built straight from the arithmetic rules predict every
// word; row/column indices are derived from the element number. Stimulus
// mixes directed runs with randomized sizes, modes, seeds and ready patterns.
// ---------------------------------------------------------------------------
module tb_random_weight_streamer;

   localparam int          DATA_W = 16;
   localparam int          DIM_W  = 8;
   localparam logic [31:0] SEED   = 32'hACE1_0001;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [DIM_W-1:0]  no_of_rows;
   logic [DIM_W-1:0]  no_of_columns;
   logic [1:0]        mode;
   logic [3:0]        shift_amt;
   logic              seed_load;
   logic [31:0]       seed_in;
   logic [DATA_W-1:0] w_data;
   logic [DIM_W-1:0]  w_row;
   logic [DIM_W-1:0]  w_col;
   logic              w_last;
   logic              w_valid;
   logic              w_ready;
   logic              busy;
   logic              done;
   logic              err;

   int          testCount = 0;
   int          failCount = 0;
   logic [31:0] modelLfsr;

   random_weight_streamer #(
      .DATA_W(DATA_W),
      .DIM_W (DIM_W),
      .SEED  (SEED)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .no_of_rows   (no_of_rows),
      .no_of_columns(no_of_columns),
      .mode         (mode),
      .shift_amt    (shift_amt),
      .seed_load    (seed_load),
      .seed_in      (seed_in),
      .w_data       (w_data),
      .w_row        (w_row),
      .w_col        (w_col),
      .w_last       (w_last),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference LFSR step
   function automatic logic [31:0] stepLfsr(input logic [31:0] s);
      if (s[0]) begin
         return (s >> 1) ^ 32'h8020_0003;
      end
      return s >> 1;
   endfunction

   // Reference weight: the scaled mode is written as floor division by a
   // power of two, which is what an arithmetic right shift amounts to.
   function automatic logic [15:0] modelWeight(input logic [31:0] s, input int md, input int sh);
      int v;
      int d;
      int q;
      v = int'($signed(s[15:0]));
      d = 1 << sh;
      if (md == 1) begin
         if (v >= 0) begin
            q = v / d;
         end else begin
            q = -((-v + d - 1) / d);
         end
         return 16'(q);
      end else if (md == 2) begin
         return s[0] ? 16'h0001 : 16'hFFFF;
      end
      return s[15:0];
   endfunction

   // Issue one start (optionally with a seed in the same cycle) and follow
   // the run to the end, checking every presented word, stall stability and
   // the done pulse. midStart pokes start/seed/dims during the run;
   // abortAfter > 0 stops following after that many handshakes.
   task automatic applyStimulus(input int rows, input int cols, input int md, input int sh,
                                input bit randReady, input bit doSeed, input logic [31:0] seedVal,
                                input bit midStart, input int abortAfter);
      int          total;
      int          hs;
      int          budget;
      int          iter;
      bit          stalled;
      logic [15:0] sData;
      logic [7:0]  sRow;
      logic [7:0]  sCol;
      logic        sLast;
      total   = rows * cols;
      hs      = 0;
      budget  = total * 8 + 20;
      iter    = 0;
      stalled = 1'b0;
      sData   = '0;
      sRow    = '0;
      sCol    = '0;
      sLast   = 1'b0;

      @(negedge clk);
      start         = 1'b1;
      no_of_rows    = DIM_W'(rows);
      no_of_columns = DIM_W'(cols);
      mode          = 2'(md);
      shift_amt     = 4'(sh);
      seed_load     = doSeed;
      seed_in       = seedVal;
      w_ready       = 1'b0;
      if (doSeed) begin
         modelLfsr = (seedVal == 32'd0) ? SEED : seedVal;
      end
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;

      while (hs < total && budget > 0 && !(abortAfter > 0 && hs >= abortAfter)) begin
         w_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (midStart && iter == 2) begin
            start         = 1'b1;
            no_of_rows    = DIM_W'(rows + 3);
            no_of_columns = DIM_W'(cols + 2);
            mode          = ~(2'(md));
            seed_load     = 1'b1;
            seed_in       = 32'h1234_5678;
         end else begin
            start     = 1'b0;
            seed_load = 1'b0;
         end
         checkOutput("validInRun", w_valid, 1);
         checkOutput("busyInRun", busy, 1);
         checkOutput("doneInRun", done, 0);
         if (stalled) begin
            checkOutput("stallData", w_data, sData);
            checkOutput("stallRow", w_row, sRow);
            checkOutput("stallCol", w_col, sCol);
            checkOutput("stallLast", w_last, sLast);
         end
         if (w_ready) begin
            checkOutput("data", w_data, modelWeight(modelLfsr, md, sh));
            checkOutput("row", w_row, hs / cols);
            checkOutput("col", w_col, hs % cols);
            checkOutput("last", w_last, (hs == total - 1) ? 1 : 0);
            modelLfsr = stepLfsr(modelLfsr);
            hs++;
            stalled = 1'b0;
         end else begin
            sData   = w_data;
            sRow    = w_row;
            sCol    = w_col;
            sLast   = w_last;
            stalled = 1'b1;
         end
         @(negedge clk);
         budget--;
         iter++;
      end
      start     = 1'b0;
      seed_load = 1'b0;

      if (abortAfter > 0) begin
         checkOutput("handshakesBeforeAbort", hs, abortAfter);
         return;
      end
      checkOutput("handshakes", hs, total);
      // Cycle after the last handshake: done pulse, still busy, no data
      checkOutput("donePulse", done, 1);
      checkOutput("validInDone", w_valid, 0);
      checkOutput("busyInDone", busy, 1);
      checkOutput("dataInDone", w_data, 0);
      @(negedge clk);
      checkOutput("doneCleared", done, 0);
      checkOutput("busyCleared", busy, 0);
      checkOutput("validIdle", w_valid, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      no_of_rows    = '0;
      no_of_columns = '0;
      mode          = '0;
      shift_amt     = '0;
      seed_load     = 1'b0;
      seed_in       = '0;
      w_ready       = 1'b0;
      #3;
      checkOutput("rstValid", w_valid, 0);
      checkOutput("rstData", w_data, 0);
      checkOutput("rstRow", w_row, 0);
      checkOutput("rstCol", w_col, 0);
      checkOutput("rstLast", w_last, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstErr", err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      modelLfsr = SEED;

      // Directed runs with seed 1 loaded alongside start
      applyStimulus(2, 3, 0, 0, 1'b0, 1'b1, 32'd1, 1'b0, 0);
      applyStimulus(1, 3, 2, 0, 1'b0, 1'b1, 32'd1, 1'b0, 0);
      applyStimulus(1, 2, 1, 1, 1'b0, 1'b1, 32'd1, 1'b0, 0);
      applyStimulus(2, 3, 0, 0, 1'b1, 1'b1, 32'd1, 1'b0, 0);

      // Zero-dimension starts are rejected with an err pulse
      for (int z = 0; z < 2; z++) begin
         @(negedge clk);
         start         = 1'b1;
         no_of_rows    = (z == 0) ? DIM_W'(0) : DIM_W'(2);
         no_of_columns = (z == 0) ? DIM_W'(3) : DIM_W'(0);
         @(negedge clk);
         start = 1'b0;
         checkOutput("errPulse", err, 1);
         checkOutput("errBusy", busy, 0);
         checkOutput("errValid", w_valid, 0);
         @(negedge clk);
         checkOutput("errCleared", err, 0);
         checkOutput("errStillIdle", w_valid, 0);
      end

      // A zero seed substitutes SEED
      applyStimulus(1, 2, 0, 0, 1'b0, 1'b1, 32'd0, 1'b0, 0);

      // start, seed_load and dimension changes during a run are ignored;
      // LFSR carries over from the previous run
      applyStimulus(3, 4, 1, 3, 1'b1, 1'b0, 32'd0, 1'b1, 0);

      // Randomized runs
      for (int i = 0; i < 8; i++) begin
         int          r;
         int          c;
         int          md;
         int          sh;
         bit          sd;
         logic [31:0] sv;
         r  = $urandom_range(1, 4);
         c  = $urandom_range(1, 5);
         md = $urandom_range(0, 3);
         sh = $urandom_range(0, 15);
         sd = 1'($urandom_range(0, 1));
         sv = $urandom;
         applyStimulus(r, c, md, sh, 1'b1, sd, sv, 1'b0, 0);
      end

      // Reset in the middle of a 4x4 run
      applyStimulus(4, 4, 0, 0, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0, 3);
      w_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abortValid", w_valid, 0);
      checkOutput("abortData", w_data, 0);
      checkOutput("abortRow", w_row, 0);
      checkOutput("abortCol", w_col, 0);
      checkOutput("abortLast", w_last, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortDone", done, 0);
      @(negedge clk);
      checkOutput("abortNoDone", done, 0);
      rst_n     = 1'b1;
      modelLfsr = SEED;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("postResetNoDone", done, 0);
         checkOutput("postResetIdle", busy, 0);
      end
      applyStimulus(1, 1, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
